// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//   Receive-side checker for the emulation LFSR pattern stream. In SEARCH it
//   watches the incoming words until LOCK_CNT consecutive words follow the
//   next-word function N(); it then free-runs a local copy of the sequence
//   and compares every accepted word against it. LOSS_THRESH consecutive
//   mismatches while LOCKED drop it back to SEARCH.
//
//   N(x) = {x[WIDTH-2:0], ~(x[19]^x[6]^x[2]^x[1])}
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous reset, active low
//   enable        data_in valid this cycle
//   data_in       received pattern word [WIDTH]
//   clear         synchronous clear of word_count / err_count (/ bit_err_count)
//   locked        checker synchronised to the sequence
//   err           1-cycle pulse: last accepted word mismatched while LOCKED
//   word_count    words compared while LOCKED, saturating [CNT_W]
//   err_count     mismatched words while LOCKED, saturating [CNT_W]
//   bit_err_count saturating sum of mismatching bits while LOCKED [CNT_W]
//                 (present only when LFSR_CHK_BITERR_EN is defined)
//
// Build option
//   LFSR_CHK_BITERR_EN : adds bit_err_count and its popcount datapath.
// ---------------------------------------------------------------------------
module lfsr_checker #(
    parameter int WIDTH       = 64,
    parameter int LOCK_CNT    = 4,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_BITERR_EN
    ,
    output logic [CNT_W-1:0] bit_err_count
`endif
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);
    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST = MISS_W'(LOSS_THRESH - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ~(x[19] ^ x[6] ^ x[2] ^ x[1])};
    endfunction

    state_t               state_reg;
    logic [WIDTH-1:0]     prev_reg;
    logic                 prev_v_reg;
    logic [WIDTH-1:0]     exp_reg;
    logic [MATCH_W-1:0]   match_cnt_reg;
    logic [MISS_W-1:0]    miss_cnt_reg;
    logic                 err_reg;
    logic [CNT_W-1:0]     word_count_reg;
    logic [CNT_W-1:0]     err_count_reg;

    logic [WIDTH-1:0]     diff;
    logic                 word_miss;

    assign diff      = data_in ^ exp_reg;
    assign word_miss = |diff;

`ifdef LFSR_CHK_BITERR_EN
    localparam int POP_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] bit_err_count_reg;
    logic [POP_W-1:0] pop;
    logic [CNT_W:0]   bit_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(diff[i]);
        end
    end

    // One extra bit catches the carry so the sum can clamp at all-ones.
    assign bit_sum       = {1'b0, bit_err_count_reg} + (CNT_W+1)'(pop);
    assign bit_err_count = bit_err_count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            bit_err_count_reg <= '0;
        end else if (enable && state_reg == LOCKED) begin
            bit_err_count_reg <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= SEARCH;
            prev_reg       <= '0;
            prev_v_reg     <= 1'b0;
            exp_reg        <= '0;
            match_cnt_reg  <= '0;
            miss_cnt_reg   <= '0;
            err_reg        <= 1'b0;
            word_count_reg <= '0;
            err_count_reg  <= '0;
        end else begin
            err_reg <= 1'b0;
            if (clear) begin
                word_count_reg <= '0;
                err_count_reg  <= '0;
            end
            if (enable) begin
                case (state_reg)
                    SEARCH: begin
                        prev_reg   <= data_in;
                        prev_v_reg <= 1'b1;
                        if (prev_v_reg && data_in == next_word(prev_reg)) begin
                            if (match_cnt_reg == LOCK_LAST) begin
                                state_reg     <= LOCKED;
                                exp_reg       <= next_word(data_in);
                                miss_cnt_reg  <= '0;
                                match_cnt_reg <= '0;
                            end else begin
                                match_cnt_reg <= match_cnt_reg + 1'b1;
                            end
                        end else begin
                            match_cnt_reg <= '0;
                        end
                    end
                    LOCKED: begin
                        // The local copy always advances from itself, so a
                        // corrupted word never propagates into later compares.
                        exp_reg <= next_word(exp_reg);
                        if (!clear && word_count_reg != '1) begin
                            word_count_reg <= word_count_reg + 1'b1;
                        end
                        if (word_miss) begin
                            err_reg <= 1'b1;
                            if (!clear && err_count_reg != '1) begin
                                err_count_reg <= err_count_reg + 1'b1;
                            end
                            if (miss_cnt_reg == MISS_LAST) begin
                                state_reg     <= SEARCH;
                                match_cnt_reg <= '0;
                                miss_cnt_reg  <= '0;
                                prev_reg      <= data_in;
                                prev_v_reg    <= 1'b1;
                            end else begin
                                miss_cnt_reg <= miss_cnt_reg + 1'b1;
                            end
                        end else begin
                            miss_cnt_reg <= '0;
                        end
                    end
                    default: state_reg <= SEARCH;
                endcase
            end
        end
    end

    assign locked     = (state_reg == LOCKED);
    assign err        = err_reg;
    assign word_count = word_count_reg;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//   Directed bench for lfsr_checker (WIDTH=32, LOCK_CNT=4, LOSS_THRESH=8,
//   CNT_W=6 so counter saturation is reachable in a few dozen words).
//   Define LFSR_CHK_BITERR_EN for both files to exercise bit_err_count.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic             clear;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;
`ifdef LFSR_CHK_BITERR_EN
    logic [CNT_W-1:0] bit_err_count;
`endif

    int checks = 0;
    int errors = 0;

    // First words of the sequence from 0, worked by hand from N().
    logic [WIDTH-1:0] head [5] = '{32'h0, 32'h1, 32'h3, 32'h6, 32'hD};
    logic [WIDTH-1:0] seq;

    lfsr_checker #(
        .WIDTH(WIDTH), .LOCK_CNT(4), .LOSS_THRESH(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in),
        .clear(clear), .locked(locked), .err(err),
        .word_count(word_count), .err_count(err_count)
`ifdef LFSR_CHK_BITERR_EN
        , .bit_err_count(bit_err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ~(x[19] ^ x[6] ^ x[2] ^ x[1])};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step(input logic rst_n, input logic en, input logic [WIDTH-1:0] d, input logic clr);
        reset_n = rst_n;
        enable  = en;
        data_in = d;
        clear   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic e,
                           input int wc, input int ec);
        check({tag, ".locked"}, 64'(locked), 64'(lk));
        check({tag, ".err"}, 64'(err), 64'(e));
        check({tag, ".word_count"}, 64'(word_count), 64'(wc));
        check({tag, ".err_count"}, 64'(err_count), 64'(ec));
    endtask

    task automatic send_ok();
        step(1'b1, 1'b1, seq, 1'b0);
        seq = nxt(seq);
    endtask

    task automatic send_bad(input logic [WIDTH-1:0] mask, input logic clr);
        step(1'b1, 1'b1, seq ^ mask, clr);
        seq = nxt(seq);
    endtask

    initial begin
        // Scenario 1: reset then lock on the head of the sequence
        step(1'b0, 1'b0, '0, 1'b0);
        chk_all("reset", 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, head[i], 1'b0);
            check($sformatf("s1.locked.w%0d", i), 64'(locked), 64'(i == 4));
            check($sformatf("s1.err.w%0d", i), 64'(err), 64'd0);
        end
        seq = 32'h1A;
        chk_all("s1.locked", 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) send_ok();
        chk_all("s1.run", 1'b1, 1'b0, 3, 0);

        // Scenario 2: single bit-0 flip
        send_bad(32'h1, 1'b0);
        chk_all("s2.bad", 1'b1, 1'b1, 4, 1);
        send_ok();
        chk_all("s2.ok1", 1'b1, 1'b0, 5, 1);
        send_ok();
        chk_all("s2.ok2", 1'b1, 1'b0, 6, 1);

        // Scenario 3: 8 consecutive bad words lose lock, then relock
        for (int i = 0; i < 8; i++) begin
            send_bad('1, 1'b0);
            chk_all($sformatf("s3.bad%0d", i), (i != 7), 1'b1, 7 + i, 2 + i);
        end
        for (int i = 0; i < 5; i++) begin
            send_ok();
            chk_all($sformatf("s3.relock%0d", i), (i == 4), 1'b0, 14, 9);
        end
        send_ok();
        chk_all("s3.run", 1'b1, 1'b0, 15, 9);

        // Scenario 4: enable every other cycle, random data while idle
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk_all("s4.reset", 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, $urandom, 1'b0);
            check($sformatf("s4.idle.locked%0d", i), 64'(locked), 64'd0);
            step(1'b1, 1'b1, head[i], 1'b0);
            check($sformatf("s4.locked.w%0d", i), 64'(locked), 64'(i == 4));
        end
        seq = 32'h1A;
        step(1'b1, 1'b0, $urandom, 1'b0);
        chk_all("s4.idle_locked", 1'b1, 1'b0, 0, 0);
        send_ok();
        chk_all("s4.run", 1'b1, 1'b0, 1, 0);

        // Scenario 5: clear beats increment; counters saturate
        send_ok();
        send_bad(32'h1, 1'b1);
        chk_all("s5.clear", 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 63; i++) send_ok();
        chk_all("s5.full", 1'b1, 1'b0, 63, 0);
        for (int i = 0; i < 5; i++) send_ok();
        chk_all("s5.sat", 1'b1, 1'b0, 63, 0);
        send_bad(32'h8000_0000, 1'b0);
        chk_all("s5.sat_err", 1'b1, 1'b1, 63, 1);

        // Scenario 6: reset while locked with err_count=5
        for (int i = 0; i < 4; i++) send_bad(32'h1, 1'b0);
        chk_all("s6.pre", 1'b1, 1'b1, 63, 5);
        step(1'b0, 1'b1, seq, 1'b0);
        chk_all("s6.reset", 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) send_ok();
        chk_all("s6.relock", 1'b1, 1'b0, 0, 0);
        send_bad(32'h0000_0111, 1'b0);
        chk_all("s6.3bit", 1'b1, 1'b1, 1, 1);
`ifdef LFSR_CHK_BITERR_EN
        check("s6.bit_err_count", 64'(bit_err_count), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
